// File: rtl/aibnd_dly_mimic_ctl.sv
// TX delay-mimic bypass sequencer: selects the DCC bypass target and applies each change
// through a quiesce / switch / settle sequence while the replica data stays frozen.
module aibnd_dly_mimic_ctl #(
  parameter int unsigned DWIDTH      = 40,
  parameter int unsigned QUIESCE_CYC = 4,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_reg6,
  input  logic              idll_core2dll_1,
  input  logic              rb_dcc_byp_dprio,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              dcc_byp_mux,
  output logic              switch_busy,
  output logic              switch_done,
  output logic [7:0]        switch_cnt
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StQuiesce = 3'd1,
    StSwitch  = 3'd2,
    StSettle  = 3'd3,
    StDone    = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] QuiesceLd = CNT_W'(QUIESCE_CYC - 1);
  localparam logic [CNT_W-1:0] SettleLd  = CNT_W'(SETTLE_CYC - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tgt_lat_q, tgt_lat_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              mux_q, mux_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        swcnt_q, swcnt_d;
  logic              idll_meta_q, idll_sync_q;
  logic              dprio_meta_q, dprio_sync_q;
  logic              tgt;

  // DPRIO bypass bit is active-low, hence the inversion.
  assign tgt = csr_reg6 ? idll_sync_q : ~dprio_sync_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_lat_d = tgt_lat_q;
    data_d    = data_q;
    mux_d     = mux_q;
    swcnt_d   = swcnt_q;
    case (state_q)
      StIdle: begin
        data_d = data_in;
        if (tgt != mux_q) begin
          tgt_lat_d = tgt;
          cnt_d     = QuiesceLd;
          state_d   = StQuiesce;
        end
      end
      StQuiesce: begin
        // A target that moves before the switch cancels the whole sequence.
        if (tgt != tgt_lat_q) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StSwitch;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSwitch: begin
        mux_d   = tgt_lat_q;
        cnt_d   = SettleLd;
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        data_d  = data_in;
        if (swcnt_q != 8'hFF) begin
          swcnt_d = swcnt_q + 8'd1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StQuiesce) || (state_d == StSwitch) || (state_d == StSettle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idll_meta_q  <= 1'b0;
      idll_sync_q  <= 1'b0;
      dprio_meta_q <= 1'b0;
      dprio_sync_q <= 1'b0;
      state_q      <= StIdle;
      cnt_q        <= '0;
      tgt_lat_q    <= 1'b0;
      data_q       <= '0;
      mux_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      swcnt_q      <= 8'd0;
    end else begin
      idll_meta_q  <= idll_core2dll_1;
      idll_sync_q  <= idll_meta_q;
      dprio_meta_q <= rb_dcc_byp_dprio;
      dprio_sync_q <= dprio_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tgt_lat_q    <= tgt_lat_d;
      data_q       <= data_d;
      mux_q        <= mux_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      swcnt_q      <= swcnt_d;
    end
  end

  assign data_out    = data_q;
  assign dcc_byp_mux = mux_q;
  assign switch_busy = busy_q;
  assign switch_done = done_q;
  assign switch_cnt  = swcnt_q;

endmodule

// File: tb/tb_aibnd_dly_mimic_ctl.sv
// Bench for aibnd_dly_mimic_ctl: per-cycle comparison against a sequence-age model,
// directed scenarios with literal expectations, then a randomized soak.
module tb_aibnd_dly_mimic_ctl;
  localparam int DW = 40;
  localparam int Q  = 4;
  localparam int S  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          csr_reg6 = 1'b1;
  logic          idll = 1'b0;
  logic          dprio = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          dcc_byp_mux, switch_busy, switch_done;
  logic [7:0]    switch_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  aibnd_dly_mimic_ctl #(
    .DWIDTH     (DW),
    .QUIESCE_CYC(Q),
    .SETTLE_CYC (S),
    .CNT_W      (5)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .csr_reg6        (csr_reg6),
    .idll_core2dll_1 (idll),
    .rb_dcc_byp_dprio(dprio),
    .data_in         (data_in),
    .data_out        (data_out),
    .dcc_byp_mux     (dcc_byp_mux),
    .switch_busy     (switch_busy),
    .switch_done     (switch_done),
    .switch_cnt      (switch_cnt)
  );

  // Model: age of the running sequence (-1 = none). Ages 0..Q-1 freeze, age Q switches,
  // ages Q+1..Q+S settle, age Q+S+1 is the completion cycle.
  logic [1:0]    m_idll_dly = '0;
  logic [1:0]    m_dprio_dly = '0;
  int            m_age = -1;
  logic          m_lat = 1'b0;
  logic          m_mux = 1'b0;
  logic [DW-1:0] m_data = '0;
  int            m_cnt = 0;

  task automatic model_step();
    logic tgt;
    if (rst) begin
      m_idll_dly  = '0;
      m_dprio_dly = '0;
      m_age = -1;
      m_lat = 1'b0;
      m_mux = 1'b0;
      m_data = '0;
      m_cnt = 0;
    end else begin
      tgt = csr_reg6 ? m_idll_dly[1] : ~m_dprio_dly[1];
      m_idll_dly  = {m_idll_dly[0], idll};
      m_dprio_dly = {m_dprio_dly[0], dprio};
      if (m_age < 0 || m_age == Q + S + 1) begin
        m_data = data_in;
        if (m_age == Q + S + 1) begin
          if (m_cnt < 255) m_cnt++;
          m_age = -1;
        end else if (tgt != m_mux) begin
          m_lat = tgt;
          m_age = 0;
        end
      end else if (m_age < Q && tgt != m_lat) begin
        m_age = -1;
      end else begin
        if (m_age == Q) m_mux = m_lat;
        m_age++;
      end
    end
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("data_out", 64'(data_out), 64'(m_data));
      check("dcc_byp_mux", 64'(dcc_byp_mux), 64'(m_mux));
      check("switch_busy", 64'(switch_busy), 64'(m_age >= 0 && m_age <= Q + S));
      check("switch_done", 64'(switch_done), 64'(m_age == Q + S + 1));
      check("switch_cnt", 64'(switch_cnt), 64'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom, $urandom});
  endfunction

  task automatic wait_busy(input string nm);
    int n = 0;
    while (!switch_busy && n < 40) begin
      tick();
      n++;
    end
    check(nm, 64'(switch_busy), 64'd1);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!switch_done && n < 80) begin
      data_in = rnd_data();
      tick();
      n++;
    end
    check(nm, 64'(switch_done), 64'd1);
  endtask

  initial begin
    int n, blen, hb, nd;
    logic [DW-1:0] last, frozen;
    logic [7:0] c0;

    chk_en = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("reset_data_out", 64'(data_out), 64'd0);
    check("reset_mux", 64'(dcc_byp_mux), 64'd0);
    check("reset_cnt", 64'(switch_cnt), 64'd0);

    // Steady state ramp: one-cycle pass-through, never busy.
    for (int k = 1; k <= 20; k++) begin
      data_in = DW'(k);
      tick();
      check("ramp_delay", 64'(data_out), 64'(k));
      check("ramp_idle", 64'(switch_busy), 64'd0);
    end

    // Full transition via the DPRIO source, tgt 0 -> 1.
    csr_reg6 = 1'b0;
    repeat (3) tick();
    dprio = 1'b0;
    n = 0;
    last = '0;
    do begin
      data_in = rnd_data();
      last = data_in;
      tick();
      n++;
    end while (!switch_busy && n < 10);
    check("edge_to_busy", 64'(n), 64'd3);
    frozen = last;
    check("frozen_value", 64'(data_out), 64'(frozen));
    blen = 0;
    while (switch_busy && blen < 60) begin
      data_in = rnd_data();
      tick();
      blen++;
    end
    check("busy_len", 64'(blen), 64'(Q + 1 + S));
    check("done_pulse", 64'(switch_done), 64'd1);
    check("still_frozen", 64'(data_out), 64'(frozen));
    check("mux_set", 64'(dcc_byp_mux), 64'd1);
    tick();
    check("cnt_one", 64'(switch_cnt), 64'd1);
    check("done_one_cycle", 64'(switch_done), 64'd0);

    // Source change back to DLL core (idll=0) is an ordinary transition to 0.
    csr_reg6 = 1'b1;
    wait_done("src_change_done");
    tick();
    tick();
    check("mux_cleared", 64'(dcc_byp_mux), 64'd0);

    // Short DLL-core pulse aborts during quiesce.
    c0 = switch_cnt;
    idll = 1'b1;
    tick();
    tick();
    idll = 1'b0;
    hb = 0;
    nd = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (switch_busy) hb++;
      if (switch_done) nd++;
    end
    check("abort_busy_len", 64'(hb >= 2 && hb <= 3), 64'd1);
    check("abort_no_done", 64'(nd), 64'd0);
    check("abort_mux", 64'(dcc_byp_mux), 64'd0);
    check("abort_cnt", 64'(switch_cnt), 64'(c0));

    // Toggle back during settle: first sequence completes, then a second one runs.
    c0 = switch_cnt;
    idll = 1'b1;
    wait_busy("t3_busy");
    repeat (Q + 1 + 3) tick();
    idll = 1'b0;
    wait_done("t3_first_done");
    tick();
    check("t3_cnt1", 64'(switch_cnt), 64'(c0 + 8'd1));
    check("t3_mux1", 64'(dcc_byp_mux), 64'd1);
    wait_done("t3_second_done");
    tick();
    check("t3_cnt2", 64'(switch_cnt), 64'(c0 + 8'd2));
    check("t3_mux0", 64'(dcc_byp_mux), 64'd0);

    // Reset mid-settle.
    idll = 1'b1;
    wait_busy("t4_busy");
    repeat (Q + 1 + 4) tick();
    check("t4_mux_before", 64'(dcc_byp_mux), 64'd1);
    rst = 1'b1;
    idll = 1'b0;
    tick();
    check("t4_mux", 64'(dcc_byp_mux), 64'd0);
    check("t4_data", 64'(data_out), 64'd0);
    check("t4_busy", 64'(switch_busy), 64'd0);
    check("t4_cnt", 64'(switch_cnt), 64'd0);
    rst = 1'b0;
    repeat (3) tick();

    // 300 alternating transitions saturate the counter.
    for (int k = 0; k < 300; k++) begin
      idll = ~idll;
      wait_done("sat_done");
      tick();
    end
    check("cnt_saturated", 64'(switch_cnt), 64'd255);

    // Randomized soak against the model.
    for (int i = 0; i < 1500; i++) begin
      data_in = rnd_data();
      if ($urandom_range(15) == 0) idll = ~idll;
      if ($urandom_range(15) == 0) dprio = ~dprio;
      if ($urandom_range(63) == 0) csr_reg6 = ~csr_reg6;
      rst = ($urandom_range(199) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
